// File: rtl/spi_reg_slave.sv
// ---------------------------------------------------------------------------
// spi_reg_slave
//
// SPI mode-0 slave. It decodes serial frames into single-cycle accesses on a
// register bank. A frame is sent MSB first and holds 1 command bit
// (1 = write, 0 = read), then ADDR_W address bits, then DATA_W data bits.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   sclk       SPI serial clock, asynchronous to clk
//   ss_n       SPI slave select, active-low, asynchronous
//   mosi       SPI serial data in, sampled on sclk rise
//   miso       SPI serial data out, updated on sclk fall
//   reg_wr     bank write strobe, high for one clk cycle
//   reg_addr   bank address, held between frames
//   reg_wdata  bank write data
//   reg_rdata  bank read data, combinational from reg_addr
//   busy       high while a frame is in progress
//   frame_err  one-cycle pulse when a frame is aborted
//
// Build option:
//   SPI_REG_BURST_EN - when defined, data words continue after the first one
//                      and reg_addr auto-increments between words. When it is
//                      not defined, bits after the first data word are ignored.
// ---------------------------------------------------------------------------
module spi_reg_slave #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sclk,
   input  logic              ss_n,
   input  logic              mosi,
   output logic              miso,
   output logic              reg_wr,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wdata,
   input  logic [DATA_W-1:0] reg_rdata,
   output logic              busy,
   output logic              frame_err
);

   localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int CNT_W = $clog2(MAX_W + 1);
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CMD  = 3'd1,
      ST_ADDR = 3'd2,
      ST_DATA = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   // Synchronizer chains; stage 3 exists only for edge detection.
   logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
   logic ss_s1_q, ss_s2_q, ss_s3_q;
   logic mosi_s1_q, mosi_s2_q;

   logic sclk_rise, sclk_fall, ss_fall, ss_rise;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              cmd_q, cmd_d;
   logic [ADDR_W-1:0] addr_sh_q, addr_sh_d;
   logic [DATA_W-1:0] data_sh_q, data_sh_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic              miso_q, miso_d;
   logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
   logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
   logic              reg_wr_q, reg_wr_d;
   logic              frame_err_q, frame_err_d;
   logic              busy_q, busy_d;
   logic              ld_tx_q, ld_tx_d;   // load tx from reg_rdata next cycle
   logic              inc_q, inc_d;       // burst: bump reg_addr after a word
   logic              word_q, word_d;     // burst: at least one word finished
   logic              complete;           // final data bit arrives this cycle

   // Bring the asynchronous SPI pins into the clk domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_s1_q <= 1'b0;
         sclk_s2_q <= 1'b0;
         sclk_s3_q <= 1'b0;
         ss_s1_q   <= 1'b0;
         ss_s2_q   <= 1'b0;
         ss_s3_q   <= 1'b0;
         mosi_s1_q <= 1'b0;
         mosi_s2_q <= 1'b0;
      end else begin
         sclk_s1_q <= sclk;
         sclk_s2_q <= sclk_s1_q;
         sclk_s3_q <= sclk_s2_q;
         ss_s1_q   <= ss_n;
         ss_s2_q   <= ss_s1_q;
         ss_s3_q   <= ss_s2_q;
         mosi_s1_q <= mosi;
         mosi_s2_q <= mosi_s1_q;
      end
   end

   // The ss chain clears to 0. If ss_n is already low when reset is released,
   // no falling edge is seen, so the block waits for a fresh select.
   assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
   assign sclk_fall = ~sclk_s2_q & sclk_s3_q;
   assign ss_fall   = ~ss_s2_q & ss_s3_q;
   assign ss_rise   = ss_s2_q & ~ss_s3_q;

   // Frame decoder: next-state and output logic.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cmd_d       = cmd_q;
      addr_sh_d   = addr_sh_q;
      data_sh_d   = data_sh_q;
      tx_d        = tx_q;
      miso_d      = miso_q;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      reg_wr_d    = 1'b0;
      frame_err_d = 1'b0;
      ld_tx_d     = 1'b0;
      inc_d       = 1'b0;
      word_d      = word_q;
      complete    = 1'b0;

      // Actions deferred by one cycle, so the write strobe still sees the old
      // address and the bank has settled before tx samples it.
      if (inc_q) begin
         reg_addr_d = reg_addr_q + ADDR_W'(1);
         ld_tx_d    = ~cmd_q;
      end else begin
         reg_addr_d = reg_addr_q;
      end
      if (ld_tx_q) begin
         tx_d = reg_rdata;
      end else begin
         tx_d = tx_q;
      end

      case (state_q)
         ST_IDLE: begin
            miso_d = 1'b0;
            if (ss_fall) begin
               state_d = ST_CMD;
               cnt_d   = '0;
               word_d  = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CMD: begin
            if (sclk_rise) begin
               cmd_d   = mosi_s2_q;
               cnt_d   = '0;
               state_d = ST_ADDR;
            end else begin
               state_d = ST_CMD;
            end
         end
         ST_ADDR: begin
            if (sclk_rise) begin
               addr_sh_d = {addr_sh_q[ADDR_W-2:0], mosi_s2_q};
               if (cnt_q == ADDR_LAST) begin
                  reg_addr_d = addr_sh_d;
                  ld_tx_d    = ~cmd_q;
                  cnt_d      = '0;
                  state_d    = ST_DATA;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               state_d = ST_ADDR;
            end
         end
         ST_DATA: begin
            if (sclk_fall) begin
               if (!cmd_q) begin
                  miso_d = tx_q[DATA_W-1];
                  tx_d   = {tx_q[DATA_W-2:0], 1'b0};
               end else begin
                  miso_d = 1'b0;
               end
            end else begin
               miso_d = miso_q;
            end
            if (sclk_rise) begin
               data_sh_d = {data_sh_q[DATA_W-2:0], mosi_s2_q};
               if (cnt_q == DATA_LAST) begin
                  complete = 1'b1;
                  cnt_d    = '0;
                  if (cmd_q) begin
                     reg_wdata_d = data_sh_d;
                     reg_wr_d    = 1'b1;
                  end else begin
                     reg_wdata_d = reg_wdata_q;
                  end
`ifdef SPI_REG_BURST_EN
                  inc_d   = 1'b1;
                  word_d  = 1'b1;
                  state_d = ST_DATA;
`else
                  miso_d  = 1'b0;
                  state_d = ST_DONE;
`endif
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_DONE: begin
            miso_d = 1'b0;
            if (ss_s2_q) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            miso_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase

      // Deselect while a frame is open. A frame whose last bit lands in the
      // same cycle still counts as complete, and in burst mode a partial
      // trailing word after a finished one is dropped silently.
      if (ss_rise && (state_q == ST_CMD || state_q == ST_ADDR || state_q == ST_DATA)) begin
         state_d = ST_IDLE;
         miso_d  = 1'b0;
         if (!complete && !word_q) begin
            frame_err_d = 1'b1;
         end else begin
            frame_err_d = 1'b0;
         end
      end else begin
         frame_err_d = 1'b0;
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         cmd_q       <= 1'b0;
         addr_sh_q   <= '0;
         data_sh_q   <= '0;
         tx_q        <= '0;
         miso_q      <= 1'b0;
         reg_addr_q  <= '0;
         reg_wdata_q <= '0;
         reg_wr_q    <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
         ld_tx_q     <= 1'b0;
         inc_q       <= 1'b0;
         word_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cmd_q       <= cmd_d;
         addr_sh_q   <= addr_sh_d;
         data_sh_q   <= data_sh_d;
         tx_q        <= tx_d;
         miso_q      <= miso_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         reg_wr_q    <= reg_wr_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
         ld_tx_q     <= ld_tx_d;
         inc_q       <= inc_d;
         word_q      <= word_d;
      end
   end

   assign miso      = miso_q;
   assign reg_wr    = reg_wr_q;
   assign reg_addr  = reg_addr_q;
   assign reg_wdata = reg_wdata_q;
   assign busy      = busy_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// ---------------------------------------------------------------------------
// tb_spi_reg_slave
//
// Self-checking bench for spi_reg_slave.
// - The bench plays the SPI master with sclk = clk/10.
// - A behavioural bank answers reg_rdata and records every write strobe.
// - Expected results come from a plain array model of the register contents,
//   which is updated from the frames the bench sends.
// ---------------------------------------------------------------------------
module tb_spi_reg_slave;
   localparam int AW   = 7;
   localparam int DW   = 8;
   localparam int HALF = 5;

   logic          clk = 1'b0;
   logic          rst_n, sclk, ss_n, mosi;
   logic          miso, reg_wr, busy, frame_err;
   logic [AW-1:0] reg_addr;
   logic [DW-1:0] reg_wdata, reg_rdata;

   logic [DW-1:0] bank  [0:(1<<AW)-1];
   logic [DW-1:0] model [0:(1<<AW)-1];
   logic [AW-1:0] wr_a_q [$];
   logic [DW-1:0] wr_d_q [$];
   int            err_cnt  = 0;
   int            miso_cnt = 0;
   int            n_checks = 0;
   int            n_pass   = 0;

   always #5 clk = ~clk;

   assign reg_rdata = bank[reg_addr];

   spi_reg_slave #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
      .miso(miso), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_rdata(reg_rdata), .busy(busy), .frame_err(frame_err)
   );

   // The bank and event log are sampled on the falling clk edge, away from
   // the edge on which the DUT updates.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (reg_wr === 1'b1) begin
            wr_a_q.push_back(reg_addr);
            wr_d_q.push_back(reg_wdata);
            bank[reg_addr] = reg_wdata;
         end
         if (frame_err === 1'b1) err_cnt = err_cnt + 1;
         if (miso === 1'b1) miso_cnt = miso_cnt + 1;
      end
   end

   task automatic ss_begin();
      ss_n = 1'b0;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic clk_bit(input logic b, output logic m);
      mosi = b;
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      m = miso;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
   endtask

   task automatic ss_finish();
      repeat (HALF) @(negedge clk);
      ss_n = 1'b1;
      repeat (4*HALF) @(negedge clk);
   endtask

   task automatic send_bits(input logic [31:0] bits, input int n, output logic [31:0] rx);
      logic m;
      rx = '0;
      for (int i = n - 1; i >= 0; i--) begin
         clk_bit(bits[i], m);
         rx = {rx[30:0], m};
      end
   endtask

   task automatic frame(input logic [31:0] bits, input int n, output logic [31:0] rx);
      ss_begin();
      send_bits(bits, n, rx);
      ss_finish();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
      repeat (4) @(negedge clk);
      n_checks++;
      if ({miso, reg_wr, reg_addr, reg_wdata, busy, frame_err} !== '0)
         $display("FAIL reset_in: outputs=%h required 0", {miso, reg_wr, reg_addr, reg_wdata, busy, frame_err});
      else n_pass++;
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      n_checks++;
      if ({miso, reg_wr, reg_addr, reg_wdata, busy, frame_err} !== '0)
         $display("FAIL reset_after: outputs=%h required 0", {miso, reg_wr, reg_addr, reg_wdata, busy, frame_err});
      else n_pass++;
   endtask

   task automatic test_write();
      logic [31:0] rx;
      int n0 = wr_a_q.size();
      ss_begin();
      send_bits({16'd0, 1'b1, 7'h05, 8'h2A}, 16, rx);
      repeat (2) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) $display("FAIL write_busy_hi: busy=%b required 1", busy); else n_pass++;
      ss_finish();
      model[5] = 8'h2A;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL write_busy_lo: busy=%b required 0", busy); else n_pass++;
      n_checks++;
      if (wr_a_q.size() != n0 + 1) $display("FAIL write_count: got %0d required %0d", wr_a_q.size() - n0, 1);
      else begin
         n_pass++;
         n_checks++;
         if (wr_a_q[n0] !== 7'h05 || wr_d_q[n0] !== 8'h2A)
            $display("FAIL write_data: addr=%h data=%h required 05/2a", wr_a_q[n0], wr_d_q[n0]);
         else n_pass++;
      end
      n_checks++;
      if (reg_addr !== 7'h05) $display("FAIL write_addr_hold: reg_addr=%h required 05", reg_addr); else n_pass++;
   endtask

   task automatic test_read();
      logic [31:0] rx;
      int n0 = wr_a_q.size();
      frame({16'd0, 1'b0, 7'h05, 8'h00}, 16, rx);
      n_checks++;
      if (rx[7:0] !== model[5]) $display("FAIL read_data: miso bits=%b required %b", rx[7:0], model[5]); else n_pass++;
      n_checks++;
      if (wr_a_q.size() != n0) $display("FAIL read_no_wr: writes=%0d required 0", wr_a_q.size() - n0); else n_pass++;
   endtask

   task automatic test_random();
      logic [31:0] rx;
      logic [AW-1:0] a, ra;
      logic [DW-1:0] d;
      logic [AW-1:0] written [$];
      int n0;
      for (int it = 0; it < 6; it++) begin
         a = AW'($urandom_range(0, (1<<AW)-1));
         d = DW'($urandom);
         n0 = wr_a_q.size();
         frame({16'd0, 1'b1, a, d}, 16, rx);
         model[a] = d;
         written.push_back(a);
         n_checks++;
         if (wr_a_q.size() != n0 + 1 || wr_a_q[n0] !== a || wr_d_q[n0] !== d)
            $display("FAIL rand_write%0d: count=%0d addr=%h data=%h required 1/%h/%h",
                     it, wr_a_q.size() - n0, wr_a_q[wr_a_q.size()-1], wr_d_q[wr_d_q.size()-1], a, d);
         else n_pass++;
         ra = written[$urandom_range(0, written.size() - 1)];
         frame({16'd0, 1'b0, ra, DW'($urandom)}, 16, rx);
         n_checks++;
         if (rx[15:0] !== {8'h00, model[ra]})
            $display("FAIL rand_read%0d: addr=%h miso=%h required %h", it, ra, rx[15:0], {8'h00, model[ra]});
         else n_pass++;
      end
   endtask

   task automatic test_abort();
      logic [31:0] rx;
      int n0 = wr_a_q.size();
      int e0 = err_cnt;
      ss_begin();
      send_bits({22'd0, 1'b1, 7'h22, 2'b01}, 10, rx);
      ss_finish();
      n_checks++;
      if (err_cnt != e0 + 1 || wr_a_q.size() != n0 || busy !== 1'b0)
         $display("FAIL abort: errs=%0d writes=%0d busy=%b required 1/0/0", err_cnt - e0, wr_a_q.size() - n0, busy);
      else n_pass++;
      frame({16'd0, 1'b1, 7'h7F, 8'hFF}, 16, rx);
      model[7'h7F] = 8'hFF;
      n_checks++;
      if (wr_a_q.size() != n0 + 1 || wr_a_q[wr_a_q.size()-1] !== 7'h7F || wr_d_q[wr_d_q.size()-1] !== 8'hFF || err_cnt != e0 + 1)
         $display("FAIL abort_recover: writes=%0d errs=%0d required 1/1 at 7f=ff", wr_a_q.size() - n0, err_cnt - e0);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [31:0] rx;
      int n0 = wr_a_q.size();
      int e0 = err_cnt;
      ss_begin();
      send_bits({16'd0, 1'b1, 7'h10, 8'hC3}, 12, rx);
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({miso, reg_wr, reg_addr, reg_wdata, busy, frame_err} !== '0)
         $display("FAIL reset_mid_outputs: outputs=%h required 0", {miso, reg_wr, reg_addr, reg_wdata, busy, frame_err});
      else n_pass++;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      // ss_n is still low across reset release: these bits must be ignored.
      send_bits({16'd0, 8'd0, 8'h0F}, 4, rx);
      n_checks++;
      if (busy !== 1'b0) $display("FAIL ss_low_release_busy: busy=%b required 0", busy); else n_pass++;
      ss_finish();
      n_checks++;
      if (wr_a_q.size() != n0 || err_cnt != e0)
         $display("FAIL reset_mid_nowr: writes=%0d errs=%0d required 0/0", wr_a_q.size() - n0, err_cnt - e0);
      else n_pass++;
      frame({16'd0, 1'b1, 7'h10, 8'hC3}, 16, rx);
      model[7'h10] = 8'hC3;
      n_checks++;
      if (wr_a_q.size() != n0 + 1 || wr_a_q[n0] !== 7'h10 || wr_d_q[n0] !== 8'hC3)
         $display("FAIL reset_mid_next: writes=%0d required 1 at 10=c3", wr_a_q.size() - n0);
      else n_pass++;
   endtask

`ifndef SPI_REG_BURST_EN
   task automatic test_extra_bits();
      logic [31:0] rx;
      int n0 = wr_a_q.size();
      int e0 = err_cnt;
      int m0 = miso_cnt;
      ss_begin();
      send_bits({16'd0, 1'b1, 7'h03, 8'h5A}, 16, rx);
      send_bits($urandom, 20, rx);
      ss_finish();
      model[3] = 8'h5A;
      n_checks++;
      if (wr_a_q.size() != n0 + 1 || wr_a_q[n0] !== 7'h03 || wr_d_q[n0] !== 8'h5A)
         $display("FAIL extra_single_wr: writes=%0d required 1 at 03=5a", wr_a_q.size() - n0);
      else n_pass++;
      n_checks++;
      if (miso_cnt != m0 || err_cnt != e0)
         $display("FAIL extra_quiet: miso_high_cycles=%0d errs=%0d required 0/0", miso_cnt - m0, err_cnt - e0);
      else n_pass++;
   endtask
`else
   task automatic test_burst();
      logic [31:0] rx;
      int n0 = wr_a_q.size();
      int e0 = err_cnt;
      frame({8'd0, 1'b1, 7'h7F, 8'h11, 8'h22}, 24, rx);
      n_checks++;
      if (wr_a_q.size() != n0 + 2)
         $display("FAIL burst_count: writes=%0d required 2", wr_a_q.size() - n0);
      else begin
         n_pass++;
         n_checks++;
         if (wr_a_q[n0] !== 7'h7F || wr_d_q[n0] !== 8'h11 || wr_a_q[n0+1] !== 7'h00 || wr_d_q[n0+1] !== 8'h22)
            $display("FAIL burst_data: %h=%h %h=%h required 7f=11 00=22", wr_a_q[n0], wr_d_q[n0], wr_a_q[n0+1], wr_d_q[n0+1]);
         else n_pass++;
      end
      n_checks++;
      if (err_cnt != e0) $display("FAIL burst_err: errs=%0d required 0", err_cnt - e0); else n_pass++;
   endtask
`endif

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write();
      test_read();
      test_random();
      test_abort();
      test_reset_mid();
`ifndef SPI_REG_BURST_EN
      test_extra_bits();
`else
      test_burst();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
